// File: rtl/inst_mem_pkg.sv
// Shared types for the banked instruction memory.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package inst_mem_pkg;

  // Burst loader states
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } ld_state_t;

  // Width of a bank select; a single bank still gets one select bit
  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inst_mem_bank.sv
// One instruction image: DEPTH x DATA_W RAM, one write port, one registered read port.
// Latency: read data registered, valid the cycle after re; a write is readable the next cycle.
// Backpressure: none; read of the address being written returns the old word.
module inst_mem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read; rdata holds when re is low
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_mem_banked.sv
// Multi-bank instruction memory with per-request bank select and a burst loader.
// Latency: fetch result one cycle after request, one fetch per cycle; loader one word per cycle.
// Backpressure: loader ld_ready high only in LOAD. Optional INST_MEM_FAULT_EN flags out-of-range fetches.
module inst_mem_banked
  import inst_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2048,
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 32,
  localparam int BANK_W   = bank_w(NUM_BANKS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic [BANK_W-1:0] fetch_bank,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              fetch_fault,
  input  logic              ld_start,
  input  logic [BANK_W-1:0] ld_bank,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W-1:0] ld_count,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_overflow
);

  localparam int IDX_W = $clog2(DEPTH);
  // One extra bit so a carry out of base+idx compares as out of range
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [BANK_W:0] NB_B    = (BANK_W+1)'(NUM_BANKS);

  ld_state_t         state, state_nx;
  logic [BANK_W-1:0] bank_q;
  logic [ADDR_W-1:0] base_q, count_q, idx_q, idx_nx;
  logic [ADDR_W:0]   waddr_full;
  logic              accept, wr_in_range, wr_en;

  assign idx_nx      = idx_q + ADDR_W'(1);
  assign accept      = (state == LOAD) && ld_valid;
  assign waddr_full  = {1'b0, base_q} + {1'b0, idx_q};
  assign wr_in_range = (waddr_full < DEPTH_A) && ({1'b0, bank_q} < NB_B);
  assign wr_en       = accept && wr_in_range && !reset;

  // Loader state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Loader next state and handshake outputs
  always_comb begin
    state_nx = state;
    ld_ready = 1'b0;
    ld_busy  = 1'b0;
    ld_done  = 1'b0;
    case (state)
      IDLE: begin
        if (ld_start) state_nx = (ld_count != '0) ? LOAD : DONE;
      end
      LOAD: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
        if (ld_valid && (idx_nx == count_q)) state_nx = DONE;
      end
      DONE: begin
        ld_done  = 1'b1;
        ld_busy  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Burst parameters, word index and sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      bank_q      <= '0;
      base_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      ld_overflow <= 1'b0;
    end else if ((state == IDLE) && ld_start) begin
      bank_q      <= ld_bank;
      base_q      <= ld_base;
      count_q     <= ld_count;
      idx_q       <= '0;
      ld_overflow <= 1'b0;
    end else if (accept) begin
      idx_q <= idx_nx;
      if (!wr_in_range) ld_overflow <= 1'b1;
    end
  end

  // Fetch range check
  logic fetch_oob;
`ifdef INST_MEM_FAULT_EN
  assign fetch_oob = ({1'b0, fetch_addr} >= DEPTH_A) || ({1'b0, fetch_bank} >= NB_B);
`else
  localparam logic [IDX_W:0] DEPTH_I = (IDX_W+1)'(DEPTH);
  logic unused_addr_hi;
  assign unused_addr_hi = ^fetch_addr[ADDR_W-1:IDX_W];
  assign fetch_oob = ({1'b0, fetch_addr[IDX_W-1:0]} >= DEPTH_I) || ({1'b0, fetch_bank} >= NB_B);
`endif

  logic [DATA_W-1:0] rdata [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    inst_mem_bank #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
    ) u_bank (
      .clock(clock),
      .we   (wr_en && (bank_q == BANK_W'(b))),
      .waddr(waddr_full[IDX_W-1:0]),
      .wdata(ld_data),
      .re   (fetch_en && !reset && !fetch_oob && (fetch_bank == BANK_W'(b))),
      .raddr(fetch_addr[IDX_W-1:0]),
      .rdata(rdata[b])
    );
  end

  logic [BANK_W-1:0] sel_q;
  logic              zero_q;

  // Bank select and zero flag travel with the read; both hold without a fetch
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_valid <= 1'b0;
      sel_q       <= '0;
      zero_q      <= 1'b1;
    end else begin
      instr_valid <= fetch_en;
      if (fetch_en) begin
        sel_q  <= fetch_bank;
        zero_q <= fetch_oob;
      end
    end
  end

`ifdef INST_MEM_FAULT_EN
  logic fault_q;
  // Fault flag of the most recent fetch
  always_ff @(posedge clock) begin
    if (reset)         fault_q <= 1'b0;
    else if (fetch_en) fault_q <= fetch_oob;
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  // Output mux; zero after reset and for out-of-range fetches
  always_comb begin
    instr_out = '0;
    if (!zero_q) instr_out = rdata[sel_q];
  end

endmodule

// File: tb/tb_inst_mem_banked.sv
// Scoreboard bench for inst_mem_banked with a behavioural memory model.
// Latency: expects fetch results one cycle after each request.
// Backpressure: loader words are driven until the DUT handshakes them.
module tb_inst_mem_banked;

  localparam int DW = 32;
  localparam int DEPTH = 24;
  localparam int NB = 3;
  localparam int AW = 32;
  localparam int BW = 2;
  localparam int IDXW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_en = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [BW-1:0] fetch_bank = '0;
  logic [DW-1:0] instr_out;
  logic          instr_valid, fetch_fault;
  logic          ld_start = 1'b0;
  logic [BW-1:0] ld_bank = '0;
  logic [AW-1:0] ld_base = '0;
  logic [AW-1:0] ld_count = '0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready, ld_busy, ld_done, ld_overflow;

  always #5 clock = ~clock;

  inst_mem_banked #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_BANKS(NB), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_bank(fetch_bank),
    .instr_out(instr_out), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
    .ld_start(ld_start), .ld_bank(ld_bank), .ld_base(ld_base), .ld_count(ld_count),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_busy(ld_busy),
    .ld_done(ld_done), .ld_overflow(ld_overflow)
  );

  int n_cmp = 0, n_bad = 0;
  int n_done = 0, exp_done = 0;
  bit mon_en = 1'b0;

  logic [DW-1:0] model [NB][DEPTH];
  logic [DW:0]   sb_q [$];
  int            cur_bank = 0;
  longint        cur_base = 0;
  int            cur_k = 0;
  bit            exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Expected {fault, data} of a fetch, from the memory image as seen before this edge's write
  function automatic logic [DW:0] expect_fetch(input logic [BW-1:0] b, input logic [AW-1:0] a);
    int unsigned ra;
`ifdef INST_MEM_FAULT_EN
    if (a >= AW'(DEPTH) || int'(b) >= NB) return {1'b1, {DW{1'b0}}};
    ra = a;
`else
    ra = a % (1 << IDXW);
    if (ra >= DEPTH || int'(b) >= NB) return '0;
`endif
    return {1'b0, model[b][ra]};
  endfunction

  // Recorder: pushes expected fetch results, then applies accepted loader words to the model
  always @(negedge clock) begin
    longint wa;
    if (reset === 1'b0) begin
      if (fetch_en === 1'b1) sb_q.push_back(expect_fetch(fetch_bank, fetch_addr));
      if (ld_valid === 1'b1 && ld_ready === 1'b1) begin
        wa = cur_base + longint'(cur_k);
        if (wa >= DEPTH || cur_bank >= NB) exp_ovf = 1'b1;
        else model[cur_bank][int'(wa)] = ld_data;
        cur_k++;
      end
    end
  end

  // Monitor: compares every presented result; checks outputs hold between fetches
  logic [DW-1:0] last_dat = '0;
  logic          last_flt = 1'b0;
  bit            prev_rst = 1'b0;
  always @(negedge clock) begin
    logic [DW:0] e;
    if (mon_en) begin
      if (ld_done === 1'b1) n_done++;
      if (prev_rst) begin
        chk("valid_after_reset", instr_valid, 0);
        chk("instr_out_after_reset", instr_out, 0);
        chk("fault_after_reset", fetch_fault, 0);
        last_dat = '0;
        last_flt = 1'b0;
      end else if (instr_valid === 1'b1) begin
        if (sb_q.size() == 0) fail_now("unexpected_instr_valid");
        else begin
          e = sb_q.pop_front();
          chk("instr_out", instr_out, e[DW-1:0]);
          chk("fetch_fault", fetch_fault, e[DW]);
          last_dat = e[DW-1:0];
          last_flt = e[DW];
        end
      end else begin
        chk("hold_instr_out", instr_out, last_dat);
        chk("hold_fetch_fault", fetch_fault, last_flt);
      end
      prev_rst = reset;
    end
  end

  task automatic rand_fetch_inputs();
    int r;
    r = $urandom_range(0, 99);
    fetch_en = ($urandom_range(0, 3) != 0);
    fetch_bank = BW'($urandom_range(0, 3));
    if (r < 8)       fetch_addr = $urandom;
    else if (r < 20) fetch_addr = $urandom_range(DEPTH, 40);
    else             fetch_addr = $urandom_range(0, DEPTH - 1);
  endtask

  task automatic fetch1(input int b, input int unsigned a);
    fetch_en = 1'b1;
    fetch_bank = b[BW-1:0];
    fetch_addr = a;
    @(posedge clock); #1;
    fetch_en = 1'b0;
  endtask

  // Runs one burst from start to the DONE cycle; called and returns just after a rising edge
  task automatic burst(input int bank, input longint base, input int cnt, input int vprob, input bit rfetch);
    logic [DW-1:0] words [$];
    int budget;
    budget = 0;
    for (int k = 0; k < cnt; k++) words.push_back($urandom);
    ld_start = 1'b1;
    ld_bank = bank[BW-1:0];
    ld_base = base[AW-1:0];
    ld_count = cnt;
    cur_bank = bank;
    cur_base = base;
    cur_k = 0;
    exp_ovf = 1'b0;
    @(posedge clock); #1;
    ld_start = 1'b0;
    while (cur_k < cnt && budget < 2000) begin
      ld_valid = ($urandom_range(0, 99) < vprob);
      ld_data = words[cur_k];
      if (rfetch) rand_fetch_inputs();
      else fetch_en = 1'b0;
      @(negedge clock);
      chk("ld_ready_in_load", ld_ready, 1);
      chk("ld_busy_in_load", ld_busy, 1);
      @(posedge clock); #1;
      budget++;
    end
    if (budget >= 2000) fail_now("burst_timeout");
    ld_valid = 1'b0;
    fetch_en = 1'b0;
    @(negedge clock);
    chk("ld_done_pulse", ld_done, 1);
    chk("ld_ready_in_done", ld_ready, 0);
    chk("ld_busy_in_done", ld_busy, 1);
    chk("ld_overflow", ld_overflow, exp_ovf);
    exp_done++;
    @(posedge clock); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    // Reset, with ld_start and fetch_en asserted on the last reset cycle
    repeat (2) @(posedge clock);
    #1;
    ld_start = 1'b1;
    ld_count = 3;
    fetch_en = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    ld_start = 1'b0;
    ld_count = 0;
    fetch_en = 1'b0;
    @(negedge clock);
    chk("rst_instr_out", instr_out, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_fetch_fault", fetch_fault, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_ld_busy", ld_busy, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_ld_overflow", ld_overflow, 0);
    mon_en = 1'b1;
    @(posedge clock); #1;

    // Fill every bank so all model contents are known
    for (int b = 0; b < NB; b++) burst(b, 0, DEPTH, 100, 1'b0);
    @(negedge clock);
    chk("idle_ld_ready", ld_ready, 0);
    chk("idle_ld_busy", ld_busy, 0);
    @(posedge clock); #1;

    // Short load into bank 1, then back-to-back fetches
    burst(1, 0, 4, 100, 1'b0);
    fetch_en = 1'b1;
    fetch_bank = 1;
    for (int a = 0; a < 4; a++) begin
      fetch_addr = a;
      @(posedge clock); #1;
    end
    fetch_en = 1'b0;

    // Alternate banks at address 5, with idle cycles that wiggle fetch_bank
    for (int i = 0; i < 10; i++) fetch1(i % 2, 5);
    for (int i = 0; i < 6; i++) begin
      fetch1(i % 2, 5);
      fetch_bank = BW'((i + 1) % 2);
      fetch_addr = 9;
      @(posedge clock); #1;
    end

    // Fetch and loader write of bank 0 address 7 in the same cycle
    ld_start = 1'b1;
    ld_bank = 0;
    ld_base = 7;
    ld_count = 1;
    cur_bank = 0;
    cur_base = 7;
    cur_k = 0;
    exp_ovf = 1'b0;
    @(posedge clock); #1;
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data = 32'hDEAD;
    fetch_en = 1'b1;
    fetch_bank = 0;
    fetch_addr = 7;
    @(posedge clock); #1;
    ld_valid = 1'b0;
    @(negedge clock);
    chk("rbw_ld_done", ld_done, 1);
    exp_done++;
    @(posedge clock); #1;
    fetch_en = 1'b0;

    // Overflow past DEPTH, bad bank, address carry-out, then a clean burst clears the flag
    burst(2, DEPTH - 2, 4, 100, 1'b0);
    fetch1(2, DEPTH - 2);
    fetch1(2, DEPTH - 1);
    fetch1(2, DEPTH);
    fetch1(0, 40);
    fetch1(3, 1);
    fetch1(1, 32'hFFFF_FFF0);
    burst(3, 0, 2, 100, 1'b0);
    burst(1, 64'hFFFF_FFFE, 3, 100, 1'b0);
    burst(0, 20, 2, 100, 1'b0);

    // Zero-length burst writes nothing
    burst(0, 3, 0, 100, 1'b0);
    fetch1(0, 3);

    // Reset after 2 of 5 words
    ld_start = 1'b1;
    ld_bank = 2;
    ld_base = 10;
    ld_count = 5;
    cur_bank = 2;
    cur_base = 10;
    cur_k = 0;
    exp_ovf = 1'b0;
    @(posedge clock); #1;
    ld_start = 1'b0;
    budget = 0;
    while (cur_k < 2 && budget < 100) begin
      ld_valid = 1'b1;
      ld_data = $urandom;
      @(posedge clock); #1;
      budget++;
    end
    if (budget >= 100) fail_now("partial_burst_timeout");
    ld_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_ld_busy", ld_busy, 0);
    chk("midrst_ld_ready", ld_ready, 0);
    chk("midrst_ld_done", ld_done, 0);
    chk("midrst_ld_overflow", ld_overflow, 0);
    @(posedge clock); #1;
    for (int a = 9; a < 14; a++) fetch1(2, a);

    // Gappy 16-word burst with concurrent random fetches, then read it back in order
    burst(1, 3, 16, 50, 1'b1);
    for (int a = 3; a < 19; a++) fetch1(1, a);

    // Random fetch traffic
    for (int i = 0; i < 300; i++) begin
      rand_fetch_inputs();
      @(posedge clock); #1;
    end
    fetch_en = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    chk("ld_done_count", n_done, exp_done);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
